// File: rtl/i2c_rx_frontend.sv
// Passive I2C receive front end: per-line sync + deglitch, START/STOP detection, byte/ACK deserialiser.
// Optional SCL-low timeout built only when I2C_RX_FRONTEND_TIMEOUT_EN is defined.

module i2c_rx_line_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt
);
    localparam int CW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // filt only follows s after GLITCH_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '1;
            filt <= 1'b1;
            cnt  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            if (s == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(GLITCH_CYCLES - 1)) begin
                filt <= s;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module i2c_rx_frontend #(
    parameter logic [6:0] VIRTUAL_ADDR   = 7'h5A,
    parameter int         SYNC_STAGES    = 2,
    parameter int         GLITCH_CYCLES  = 3,
    parameter int         TIMEOUT_CYCLES = 1_250_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_is_addr_o,
    output logic       rw_o,
    output logic       addr_match_o,
    output logic       ack_valid_o,
    output logic       nack_o,
    output logic       timeout_o
);
    localparam int NUM_LANES = 2;  // lane 0 = SCL, lane 1 = SDA

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

    logic [NUM_LANES-1:0] raw, filt, filt_q;
    logic                 scl_f, sda_f, scl_q, sda_q;
    logic                 start_det, stop_det, scl_rise, tmo_hit;
    state_t               state;
    logic [3:0]           bit_cnt;
    logic [6:0]           shreg;

    assign raw = {sda_in, scl_in};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        i2c_rx_line_filter #(
            .SYNC_STAGES  (SYNC_STAGES),
            .GLITCH_CYCLES(GLITCH_CYCLES)
        ) u_filt (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[l]),
            .filt (filt[l])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) filt_q <= '1;
        else        filt_q <= filt;
    end

    assign scl_f = filt[0];
    assign sda_f = filt[1];
    assign scl_q = filt_q[0];
    assign sda_q = filt_q[1];

    // SCL must be high on both sides of the SDA edge for a bus condition
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign scl_rise  = scl_f & ~scl_q;

`ifdef I2C_RX_FRONTEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = busy_o & ~scl_f & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                tmo_cnt <= '0;
        else if (!busy_o || scl_f) tmo_cnt <= '0;
        else if (!tmo_hit)         tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shreg          <= '0;
            start_o        <= 1'b0;
            stop_o         <= 1'b0;
            busy_o         <= 1'b0;
            byte_valid_o   <= 1'b0;
            byte_data_o    <= '0;
            byte_is_addr_o <= 1'b0;
            rw_o           <= 1'b0;
            addr_match_o   <= 1'b0;
            ack_valid_o    <= 1'b0;
            nack_o         <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            start_o      <= 1'b0;
            stop_o       <= 1'b0;
            byte_valid_o <= 1'b0;
            ack_valid_o  <= 1'b0;
            timeout_o    <= 1'b0;
            if (start_det) begin
                state        <= ADDR;
                bit_cnt      <= '0;
                addr_match_o <= 1'b0;
                busy_o       <= 1'b1;
                start_o      <= 1'b1;
            end else if (stop_det) begin
                state        <= IDLE;
                bit_cnt      <= '0;
                addr_match_o <= 1'b0;
                busy_o       <= 1'b0;
                stop_o       <= 1'b1;
            end else if (tmo_hit) begin
                state        <= IDLE;
                bit_cnt      <= '0;
                addr_match_o <= 1'b0;
                busy_o       <= 1'b0;
                timeout_o    <= 1'b1;
            end else if (scl_rise) begin
                case (state)
                    ADDR, DATA: begin
                        shreg <= {shreg[5:0], sda_f};
                        if (bit_cnt == 4'd7) begin
                            byte_valid_o   <= 1'b1;
                            byte_data_o    <= {shreg, sda_f};
                            byte_is_addr_o <= (state == ADDR);
                            if (state == ADDR) begin
                                rw_o         <= sda_f;
                                addr_match_o <= (shreg == VIRTUAL_ADDR);
                            end
                            bit_cnt <= 4'd8;
                            state   <= ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ACK: begin
                        ack_valid_o <= 1'b1;
                        nack_o      <= sda_f;
                        bit_cnt     <= '0;
                        state       <= DATA;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_rx_frontend.sv
// Scoreboard bench for i2c_rx_frontend: directed I2C frames, expected events queued, monitor compares.
// Timeout scenario follows I2C_RX_FRONTEND_TIMEOUT_EN.

module tb_i2c_rx_frontend;
    localparam int K_START = 0, K_STOP = 1, K_BYTE = 2, K_ACK = 3, K_TMO = 4;
    localparam int Q = 6, H = 12;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       is_addr, rw, match, nack;
    } exp_t;

    logic clk = 1'b0, reset = 1'b0, scl_in = 1'b1, sda_in = 1'b1;
    logic start_o, stop_o, busy_o, byte_valid_o, byte_is_addr_o, rw_o;
    logic addr_match_o, ack_valid_o, nack_o, timeout_o;
    logic [7:0] byte_data_o;

    exp_t q[$];
    int   checks = 0, failures = 0;

    always #10 clk = ~clk;

    i2c_rx_frontend #(
        .VIRTUAL_ADDR  (7'h5A),
        .SYNC_STAGES   (2),
        .GLITCH_CYCLES (3),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .scl_in        (scl_in),
        .sda_in        (sda_in),
        .start_o       (start_o),
        .stop_o        (stop_o),
        .busy_o        (busy_o),
        .byte_valid_o  (byte_valid_o),
        .byte_data_o   (byte_data_o),
        .byte_is_addr_o(byte_is_addr_o),
        .rw_o          (rw_o),
        .addr_match_o  (addr_match_o),
        .ack_valid_o   (ack_valid_o),
        .nack_o        (nack_o),
        .timeout_o     (timeout_o)
    );

    // Monitor: every output pulse must match the head of the expectation queue
    always @(negedge clk) begin
        if (reset && (start_o | stop_o | byte_valid_o | ack_valid_o | timeout_o)) begin
            int   k;
            logic ok;
            exp_t e;
            k = start_o ? K_START : stop_o ? K_STOP : byte_valid_o ? K_BYTE :
                ack_valid_o ? K_ACK : K_TMO;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event kind=%0d data=%h (no event expected)", k, byte_data_o);
            end else begin
                e  = q.pop_front();
                ok = (k == e.kind);
                case (k)
                    K_START: ok = ok && busy_o;
                    K_STOP, K_TMO: ok = ok && !busy_o && !addr_match_o;
                    K_BYTE:  ok = ok && byte_data_o == e.data && byte_is_addr_o == e.is_addr &&
                                  rw_o == e.rw && addr_match_o == e.match;
                    K_ACK:   ok = ok && nack_o == e.nack;
                    default: ok = 1'b0;
                endcase
                if (!ok) begin
                    failures++;
                    $display("FAIL event got kind=%0d data=%h addr=%b rw=%b match=%b nack=%b busy=%b; want kind=%0d data=%h addr=%b rw=%b match=%b nack=%b",
                             k, byte_data_o, byte_is_addr_o, rw_o, addr_match_o, nack_o, busy_o,
                             e.kind, e.data, e.is_addr, e.rw, e.match, e.nack);
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] data, input logic is_addr,
                        input logic rw, input logic match, input logic nack);
        exp_t e;
        e.kind = kind; e.data = data; e.is_addr = is_addr;
        e.rw = rw; e.match = match; e.nack = nack;
        q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        clks(Q); sda_in = b;
        clks(Q); scl_in = 1'b1;
        clks(H); scl_in = 1'b0;
    endtask

    task automatic send_start();
        push(K_START, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        clks(Q); sda_in = 1'b1;
        clks(Q); scl_in = 1'b1;
        clks(H); sda_in = 1'b0;
        clks(H); scl_in = 1'b0;
    endtask

    task automatic send_stop();
        push(K_STOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        clks(Q); sda_in = 1'b0;
        clks(Q); scl_in = 1'b1;
        clks(H); sda_in = 1'b1;
        clks(H);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic is_addr, input logic rw,
                             input logic match, input logic nack);
        push(K_BYTE, b, is_addr, rw, match, 1'b0);
        push(K_ACK, 8'h00, 1'b0, 1'b0, 1'b0, nack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(nack);
    endtask

    task automatic sda_pulse(input int n);
        sda_in = 1'b0;
        clks(n);
        sda_in = 1'b1;
        clks(H);
    endtask

    function automatic logic [17:0] outs();
        return {start_o, stop_o, busy_o, byte_valid_o, byte_data_o, byte_is_addr_o,
                rw_o, addr_match_o, ack_valid_o, nack_o, timeout_o};
    endfunction

    initial begin
        clks(3);
        chk("reset_outputs", 32'(outs()), 32'h0);
        reset = 1'b1;
        clks(10);

        // 1: write to 0x5A, data 0xC0
        send_start();
        send_byte(8'hB4, 1'b1, 1'b0, 1'b1, 1'b0);
        send_byte(8'hC0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_stop();
        clks(10);
        chk("match_after_stop", 32'(addr_match_o), 32'h0);
        chk("idle_after_stop", 32'(busy_o), 32'h0);

        // 2: foreign address, NACKed
        send_start();
        send_byte(8'h36, 1'b1, 1'b0, 1'b0, 1'b1);
        send_stop();
        clks(10);
        chk("nack_held", 32'(nack_o), 32'h1);

        // 3: write, repeated START, read
        send_start();
        send_byte(8'hB4, 1'b1, 1'b0, 1'b1, 1'b0);
        send_byte(8'hAB, 1'b0, 1'b0, 1'b1, 1'b0);
        send_start();
        chk("busy_after_rstart", 32'(busy_o), 32'h1);
        send_byte(8'hB5, 1'b1, 1'b1, 1'b1, 1'b0);
        send_stop();
        clks(10);
        chk("rw_held", 32'(rw_o), 32'h1);

        // 4: glitches on SDA while SCL high
        clks(H);
        sda_pulse(1);
        sda_pulse(2);
        chk("glitch_no_busy", 32'(busy_o), 32'h0);
        push(K_START, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        push(K_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        sda_pulse(3);
        clks(H);

        // 5: reset mid-address, then the rest of the frame must be ignored
        send_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        reset = 1'b0;
        clks(4);
        chk("midframe_reset_outputs", 32'(outs()), 32'h0);
        reset = 1'b1;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        clks(H);
        chk("no_byte_after_reset", 32'(q.size()), 32'h0);
        chk("idle_after_reset", 32'(busy_o), 32'h0);
        send_start();
        send_byte(8'hB4, 1'b1, 1'b0, 1'b1, 1'b0);
        send_byte(8'h5C, 1'b0, 1'b0, 1'b1, 1'b1);
        send_stop();
        clks(H);

        // 6: SCL held low after START
        send_start();
`ifdef I2C_RX_FRONTEND_TIMEOUT_EN
        push(K_TMO, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        clks(1200);
        chk("busy_after_timeout", 32'(busy_o), 32'h0);
`else
        clks(1200);
        chk("busy_no_timeout", 32'(busy_o), 32'h1);
`endif
        send_stop();
        clks(40);
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
